conv2_filter_sched: RTL and testbench
=====================================

Name: conv2_filter_sched

Overview:
- Sequencer that time-shares one 3-input-channel 5x5 convolution-sum datapath (14-bit result) across N_FILT output filters of the 2nd conv layer.
- Accepts one window handshake from the line buffer and holds the buffer while it runs.
- Issues one datapath launch per filter, with the weight-bank select, and collects the N_FILT results into a packed output word.
- Counts windows per feature map and flags frame completion.

Parameters:
- N_FILT, 3, number of output filters sharing the datapath (>=1).
- DW, 14, width of one datapath result.
- WIN_PER_FRAME, 64, windows per feature map (8x8 output).
- TIMEOUT, 16, maximum cycles in WAIT before abort.
- SW, max(1, ceil(log2(N_FILT))), width of wsel (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- win_valid  in  1  buffer presents a complete 5x5x3 window
- win_ready  out  1  controller accepts window; buffer must not advance while low
- calc_en  out  1  launch datapath for filter wsel
- wsel  out  SW  weight-bank/filter index for current launch
- calc_valid  in  1  datapath result valid (fixed latency after calc_en, >=1)
- calc_result  in  DW  signed datapath result
- out_valid  out  1  packed results available
- out_ready  in  1  downstream accepts
- out_data  out  N_FILT*DW  filter i at bits [i*DW+DW-1 : i*DW]
- frame_done  out  1  one-cycle pulse on acceptance of last window of a frame
- err  out  1  sticky protocol/timeout error

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, win_ready=0, calc_en=0, wsel=0, out_valid=0, out_data=0, frame_done=0, err=0, all counters 0. Applies mid-operation; the in-flight window is discarded and late calc_valid pulses after reset are ignored with no err.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: win_ready=1.
  - win_valid & win_ready at edge T -> ISSUE; issue_idx=0, ret_idx=0.
- ISSUE: calc_en=1, wsel=issue_idx, on cycles T+1 .. T+N_FILT (wsel 0..N_FILT-1 in order).
  - After the last launch -> WAIT. Go directly to OUT if all results have already returned.
- Result capture (ISSUE or WAIT): each calc_valid writes calc_result into slot ret_idx, then ret_idx++.
  - Results are matched in launch order.
  - When ret_idx reaches N_FILT -> OUT on the next cycle; out_valid asserts the cycle after the final result is captured.
- WAIT: cycle counter increments each cycle.
  - If TIMEOUT cycles elapse without completion: err<=1, out_data unchanged, window dropped, -> IDLE. win_cnt is not incremented.
- OUT: out_valid=1, out_data stable until out_valid & out_ready.
  - On that edge: out_valid<=0, -> IDLE.
  - win_cnt++; if win_cnt==WIN_PER_FRAME-1, frame_done pulses for one cycle and win_cnt wraps to 0.
  - One bubble cycle before the next window acceptance (win_ready high from the cycle after the handshake).
- Throughput: one window per N_FILT + LAT + 2 cycles minimum, where LAT is the datapath latency.
- calc_valid in IDLE or OUT, or any calc_valid beyond N_FILT returns in one window: err<=1, result ignored.
- err clears only on reset.
- Results are passed through unmodified (no saturation). out_data is retained after the handshake until overwritten.

Test Plan:
- Single window, datapath LAT=2, N_FILT=3, results 0x0123, 0x3FFF, 0x2000; handshake at T -> calc_en high T+1..T+3 with wsel 0,1,2; out_valid rises at T+6; out_data=0x2000_3FFF_0123 packed (bits 41:28=0x2000, 27:14=0x3FFF, 13:0=0x0123); win_ready low T+1..T+6.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable, win_ready=0, no calc_en; release -> IDLE next cycle, win_ready=1.
- Frame: 64 back-to-back windows, out_ready=1 -> frame_done pulses exactly once, on the 64th output handshake; the 65th window starts win_cnt at 0 and the next frame_done comes after 64 more windows.
- Timeout: suppress the 3rd calc_valid, TIMEOUT=16 -> err=1 after 16 WAIT cycles, out_valid never asserts, state returns to IDLE (win_ready=1), win_cnt unchanged.
- Spurious return: calc_valid pulse in IDLE -> err=1, no state change; the next window still completes correctly.
- Reset mid-WAIT: assert rst_n=0 for one cycle after the 1st return -> all outputs zero; late calc_valid in IDLE after reset gives err=0 and is ignored.

Source files
------------

// File: rtl/conv2_filter_sched.sv
// conv2_filter_sched: shares one conv-sum datapath across N_FILT output filters.
// Accepts a window, launches one datapath op per filter, collects results in
// launch order, presents them as one packed word and counts windows per frame.
module conv2_filter_sched #(
    parameter int unsigned N_FILT        = 3,
    parameter int unsigned DW            = 14,
    parameter int unsigned WIN_PER_FRAME = 64,
    parameter int unsigned TIMEOUT       = 16,
    localparam int unsigned SW           = (N_FILT > 1) ? $clog2(N_FILT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   win_valid,
    output logic                   win_ready,
    output logic                   calc_en,
    output logic [SW-1:0]          wsel,
    input  logic                   calc_valid,
    input  logic [DW-1:0]          calc_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_FILT*DW-1:0]   out_data,
    output logic                   frame_done,
    output logic                   err
);

    localparam int unsigned CW = $clog2(N_FILT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned FW = (WIN_PER_FRAME > 1) ? $clog2(WIN_PER_FRAME) : 1;
    localparam int unsigned OW = N_FILT * DW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          win_ready_q, win_ready_d;
    logic          calc_en_q, calc_en_d;
    logic [SW-1:0] wsel_q, wsel_d;
    logic [CW-1:0] issue_q, issue_d;
    logic [CW-1:0] ret_q, ret_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [FW-1:0] win_cnt_q, win_cnt_d;
    logic [OW-1:0] res_q, res_d;
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;
    // Set once a window has been launched since reset; returns arriving before
    // that belong to a pre-reset window and are dropped silently.
    logic          armed_q, armed_d;
    logic          cap_c;

    assign win_ready  = win_ready_q;
    assign calc_en    = calc_en_q;
    assign wsel       = wsel_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

    // A return is captured only while a window is in flight and has open slots.
    assign cap_c = calc_valid && ((state_q == S_ISSUE) || (state_q == S_WAIT))
                   && (ret_q < CW'(N_FILT));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        win_ready_d  = win_ready_q;
        calc_en_d    = calc_en_q;
        wsel_d       = wsel_q;
        issue_d      = issue_q;
        ret_d        = ret_q;
        wait_d       = wait_q;
        win_cnt_d    = win_cnt_q;
        res_d        = res_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        armed_d      = armed_q;

        if (cap_c) begin
            for (int unsigned i = 0; i < N_FILT; i++) begin
                if (ret_q == CW'(i)) begin
                    res_d[i*DW +: DW] = calc_result;
                end
            end
            ret_d = ret_q + CW'(1);
        end else if (calc_valid && armed_q) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                win_ready_d = 1'b1;
                if (win_valid && win_ready_q) begin
                    state_d     = S_ISSUE;
                    win_ready_d = 1'b0;
                    calc_en_d   = 1'b1;
                    wsel_d      = '0;
                    issue_d     = CW'(1);
                    ret_d       = '0;
                    armed_d     = 1'b1;
                end
            end
            S_ISSUE: begin
                if (issue_q < CW'(N_FILT)) begin
                    calc_en_d = 1'b1;
                    wsel_d    = SW'(issue_q);
                    issue_d   = issue_q + CW'(1);
                end else begin
                    calc_en_d = 1'b0;
                    wait_d    = '0;
                    if (ret_d == CW'(N_FILT)) begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = res_d;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ret_d == CW'(N_FILT)) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = res_d;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    state_d     = S_IDLE;
                    win_ready_d = 1'b1;
                    err_d       = 1'b1;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            default: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    win_ready_d = 1'b1;
                    if (win_cnt_q == FW'(WIN_PER_FRAME - 1)) begin
                        win_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        win_cnt_d = win_cnt_q + FW'(1);
                    end
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            win_ready_q  <= 1'b0;
            calc_en_q    <= 1'b0;
            wsel_q       <= '0;
            issue_q      <= '0;
            ret_q        <= '0;
            wait_q       <= '0;
            win_cnt_q    <= '0;
            res_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_ready_q  <= win_ready_d;
            calc_en_q    <= calc_en_d;
            wsel_q       <= wsel_d;
            issue_q      <= issue_d;
            ret_q        <= ret_d;
            wait_q       <= wait_d;
            win_cnt_q    <= win_cnt_d;
            res_q        <= res_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            armed_q      <= armed_d;
        end
    end

endmodule

// File: tb/tb_conv2_filter_sched.sv
// Directed bench for conv2_filter_sched with a 2-cycle-latency datapath model.
module tb_conv2_filter_sched;

    localparam int unsigned N_FILT = 3;
    localparam int unsigned DW     = 14;
    localparam int unsigned SW     = 2;
    localparam int unsigned OW     = N_FILT * DW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            win_valid;
    logic            win_ready;
    logic            calc_en;
    logic [SW-1:0]   wsel;
    logic            calc_valid;
    logic [DW-1:0]   calc_result;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            frame_done;
    logic            err;

    // Datapath model controls
    logic [DW-1:0]   res_tab [3];
    logic            spur      = 1'b0;
    logic            drop_last = 1'b0;
    logic [1:0]      v_pipe    = 2'b00;
    logic [SW-1:0]   w0        = '0;
    logic [SW-1:0]   w1        = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int hs, fd_cnt, fd1, fd2, ncyc, first_err;
    logic ov_seen;

    conv2_filter_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .calc_en     (calc_en),
        .wsel        (wsel),
        .calc_valid  (calc_valid),
        .calc_result (calc_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Datapath: result for a launch appears two cycles after calc_en.
    always @(posedge clk) begin
        v_pipe <= {v_pipe[0], calc_en};
        w0     <= wsel;
        w1     <= w0;
    end

    assign calc_valid  = (v_pipe[1] && !(drop_last && (w1 == 2'd2))) || spur;
    assign calc_result = (w1 < 2'd3) ? res_tab[w1] : '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present();
        for (int i = 0; i < 20 && !win_ready; i++) @(negedge clk);
        check("win_ready_pre", 64'(win_ready), 64'd1);
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
        check("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; win_valid = 1'b0; out_ready = 1'b0;
        res_tab[0] = '0; res_tab[1] = '0; res_tab[2] = '0;
        repeat (3) @(negedge clk);
        check("rst_win_ready", 64'(win_ready), 64'd0);
        check("rst_calc_en",   64'(calc_en),   64'd0);
        check("rst_wsel",      64'(wsel),      64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_frame_done",64'(frame_done),64'd0);
        check("rst_err",       64'(err),       64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_win_ready", 64'(win_ready), 64'd1);

        // Single window, exact cycle timing
        res_tab[0] = 14'h0123; res_tab[1] = 14'h3FFF; res_tab[2] = 14'h2000;
        out_ready = 1'b1;
        win_valid = 1'b1;
        @(negedge clk); win_valid = 1'b0;               // after T
        check("t1_en0",   64'(calc_en),   64'd1);
        check("t1_wsel0", 64'(wsel),      64'd0);
        check("t1_wr0",   64'(win_ready), 64'd0);
        @(negedge clk);
        check("t1_en1",   64'(calc_en),   64'd1);
        check("t1_wsel1", 64'(wsel),      64'd1);
        @(negedge clk);
        check("t1_en2",   64'(calc_en),   64'd1);
        check("t1_wsel2", 64'(wsel),      64'd2);
        @(negedge clk);
        check("t1_en_off",64'(calc_en),   64'd0);
        check("t1_ov3",   64'(out_valid), 64'd0);
        check("t1_wr3",   64'(win_ready), 64'd0);
        @(negedge clk);
        check("t1_ov4",   64'(out_valid), 64'd0);
        @(negedge clk);                                   // T+6
        check("t1_ov5",   64'(out_valid), 64'd1);
        check("t1_data",  64'(out_data),  64'h200_0FFF_C123);
        check("t1_wr5",   64'(win_ready), 64'd0);
        @(negedge clk);
        check("t1_ov_off",64'(out_valid), 64'd0);
        check("t1_wr_on", 64'(win_ready), 64'd1);
        check("t1_fd",    64'(frame_done),64'd0);

        // Backpressure in OUT
        res_tab[0] = 14'h0001; res_tab[1] = 14'h1555; res_tab[2] = 14'h2AAA;
        out_ready = 1'b0;
        present();
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ov",   64'(out_valid), 64'd1);
            check("bp_data", 64'(out_data),  64'({14'h2AAA, 14'h1555, 14'h0001}));
            check("bp_wr",   64'(win_ready), 64'd0);
            check("bp_en",   64'(calc_en),   64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ov", 64'(out_valid), 64'd0);
        check("bp_rel_wr", 64'(win_ready), 64'd1);
        check("bp_keep",   64'(out_data),  64'({14'h2AAA, 14'h1555, 14'h0001}));

        // Spurious return in IDLE
        spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        check("sp_err", 64'(err),       64'd1);
        check("sp_wr",  64'(win_ready), 64'd1);
        check("sp_en",  64'(calc_en),   64'd0);
        check("sp_ov",  64'(out_valid), 64'd0);
        res_tab[0] = 14'h1FFF; res_tab[1] = 14'h0000; res_tab[2] = 14'h3000;
        present();
        wait_out_valid();
        check("sp_data", 64'(out_data), 64'({14'h3000, 14'h0000, 14'h1FFF}));
        @(negedge clk);
        check("sp_ov_off", 64'(out_valid), 64'd0);
        check("sp_sticky", 64'(err),       64'd1);

        // Reset clears err
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("rst2_err", 64'(err), 64'd0);
        @(negedge clk);
        check("rst2_wr",  64'(win_ready), 64'd1);

        // Two frames of back-to-back windows
        hs = 0; fd_cnt = 0; fd1 = -1; fd2 = -1; ncyc = 0;
        out_ready = 1'b1; win_valid = 1'b1;
        for (int c = 0; c < 2000 && hs < 128; c++) begin
            @(negedge clk);
            ncyc++;
            if (frame_done) begin
                fd_cnt++;
                if (fd_cnt == 1) fd1 = hs; else fd2 = hs;
            end
            if (out_valid && out_ready) hs++;
        end
        win_valid = 1'b0;
        @(negedge clk);
        if (frame_done) begin
            fd_cnt++;
            if (fd_cnt == 1) fd1 = hs; else fd2 = hs;
        end
        check("fr_hs",     64'(hs),     64'd128);
        check("fr_cycles", 64'(ncyc),   64'd895);
        check("fr_count",  64'(fd_cnt), 64'd2);
        check("fr_first",  64'(fd1),    64'd64);
        check("fr_second", 64'(fd2),    64'd128);
        check("fr_err",    64'(err),    64'd0);

        // Timeout: third return suppressed
        drop_last = 1'b1;
        first_err = -1; ov_seen = 1'b0;
        present();
        for (int k = 1; k < 40 && first_err < 0; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
            if (err) first_err = k;
        end
        check("to_cycle",  64'(first_err), 64'd19);
        check("to_wr",     64'(win_ready), 64'd1);
        check("to_ov",     64'(ov_seen),   64'd0);
        check("to_wincnt", 64'(dut.win_cnt_q), 64'd0);
        repeat (3) @(negedge clk);
        drop_last = 1'b0;
        check("to_ov_late", 64'(out_valid), 64'd0);

        // Reset during WAIT, late returns ignored
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        res_tab[0] = 14'h0AAA; res_tab[1] = 14'h0BBB; res_tab[2] = 14'h0CCC;
        present();
        repeat (3) @(negedge clk);                         // first return captured
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("rw_wr",   64'(win_ready), 64'd0);
        check("rw_en",   64'(calc_en),   64'd0);
        check("rw_wsel", 64'(wsel),      64'd0);
        check("rw_ov",   64'(out_valid), 64'd0);
        check("rw_data", 64'(out_data),  64'd0);
        check("rw_fd",   64'(frame_done),64'd0);
        check("rw_err",  64'(err),       64'd0);
        @(negedge clk);
        check("rw_late_err", 64'(err),       64'd0);
        check("rw_late_wr",  64'(win_ready), 64'd1);
        @(negedge clk);
        check("rw_late_err2",64'(err),       64'd0);
        check("rw_late_ov",  64'(out_valid), 64'd0);
        check("rw_late_en",  64'(calc_en),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
